// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
//
// Purpose
//   Round-robin sequencer that drives the 2-bit select of a downstream 4:1 mux.
//   Four request lines are arbitrated round-robin. Each grant is held for a
//   bounded dwell time, counted only while the downstream consumer is ready.
//   The granted index is presented as a registered select plus a one-hot grant
//   back to the requesters. When a grant ends and another request is pending,
//   the next grant is issued in the same cycle, with no idle gap.
//
// Parameters
//   DWELL  maximum counted cycles per grant before forced re-arbitration (>=1)
//   CNT_W  dwell counter width; 2**CNT_W must exceed DWELL
//
// Ports
//   clk        in   1  single clock, all logic on posedge
//   rst        in   1  synchronous, active-high reset
//   req        in   4  request per mux input (bit i -> mux input i)
//   out_ready  in   1  downstream consuming; dwell counts only when high
//   lock       in   1  (SEL_LOCK_EN only) hold the current grant past dwell
//   sel        out  2  mux select, registered
//   sel_valid  out  1  sel holds an active grant
//   grant      out  4  one-hot grant, (1 << sel) when sel_valid, else 0
//   busy       out  1  FSM is in the GRANT state
//
// Configuration
//   SEL_LOCK_EN  when defined, adds the 'lock' input. While lock is high in
//                GRANT, dwell expiry is suppressed and the dwell counter
//                saturates at DWELL-1, so only a dropped request releases.
// -----------------------------------------------------------------------------
module mux_sel_arbiter #(
    parameter int unsigned DWELL = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       out_ready,
`ifdef SEL_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic [3:0] grant,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Last counted cycle of a grant; reaching it with out_ready high ends the dwell.
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    // Round-robin search: first set bit at ptr+1, ptr+2, ptr+3, then ptr itself.
    // Because ptr itself is searched last, the current owner is granted again
    // only when no other input is requesting.
    function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] p);
        pick_t      res;
        logic [1:0] cand;
        res = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = p + i[1:0];
            if (!res.found && r[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    state_t           state,     state_n;
    logic [1:0]       sel_n;
    logic             sel_valid_n;
    logic [3:0]       grant_n;
    logic [CNT_W-1:0] cnt,       cnt_n;
    logic [1:0]       ptr,       ptr_n;

    pick_t            pick;
    logic             lock_active;
    logic             req_held;
    logic             dwell_expired;
    logic             release_now;

`ifdef SEL_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    // In GRANT, ptr always equals sel, so one search from ptr serves both the
    // initial grant out of IDLE and re-arbitration on release. A dropped
    // request is already clear in req; a still-held request on dwell expiry
    // stays visible and is reached last, which gives the re-grant case.
    assign pick          = rr_pick(req, ptr);
    assign req_held      = req[sel];
    assign dwell_expired = out_ready && (cnt == DWELL_LAST) && !lock_active;
    assign release_now   = !req_held || dwell_expired;

    // NOTE: every signal written here is given a default first, so no path
    // leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_n     = state;
        sel_n       = sel;
        sel_valid_n = sel_valid;
        grant_n     = grant;
        cnt_n       = cnt;
        ptr_n       = ptr;

        unique case (state)
            IDLE: begin
                if (pick.found) begin
                    state_n     = GRANT;
                    sel_n       = pick.idx;
                    sel_valid_n = 1'b1;
                    grant_n     = 4'b0001 << pick.idx;
                    cnt_n       = '0;
                    ptr_n       = pick.idx;
                end
            end

            GRANT: begin
                if (release_now) begin
                    if (pick.found) begin
                        // Hand over (or re-grant) in the same cycle: no gap.
                        sel_n       = pick.idx;
                        sel_valid_n = 1'b1;
                        grant_n     = 4'b0001 << pick.idx;
                        cnt_n       = '0;
                        ptr_n       = pick.idx;
                    end else begin
                        state_n     = IDLE;
                        sel_valid_n = 1'b0;
                        grant_n     = '0;
                        cnt_n       = '0;
                    end
                end else if (out_ready && (cnt != DWELL_LAST)) begin
                    // Without lock, cnt==DWELL_LAST with out_ready always
                    // releases, so the guard only matters for the saturating
                    // locked case. The counter can never wrap.
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n     = IDLE;
                sel_valid_n = 1'b0;
                grant_n     = '0;
                cnt_n       = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'd0;
            sel_valid <= 1'b0;
            grant     <= 4'b0000;
            cnt       <= '0;
            ptr       <= 2'd3;  // first search after reset starts at index 0
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            sel_valid <= sel_valid_n;
            grant     <= grant_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
//
// Directed self-checking bench for mux_sel_arbiter with DWELL=16.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, so each observation reflects the preceding edge.
// -----------------------------------------------------------------------------
module tb_mux_sel_arbiter;

    localparam int DWELL = 16;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
`ifdef SEL_LOCK_EN
    logic       lock;
`endif
    logic [1:0] sel;
    logic       sel_valid;
    logic [3:0] grant;
    logic       busy;

    int tests_run;
    int tests_failed;

    mux_sel_arbiter #(
        .DWELL (DWELL),
        .CNT_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
`ifdef SEL_LOCK_EN
        .lock      (lock),
`endif
        .sel       (sel),
        .sel_valid (sel_valid),
        .grant     (grant),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset for one edge, then release reset while presenting r.
    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = 4'b0000;
        tick(1);
        rst = 1'b0;
        req = r;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick(1);
            tests_run++;
            if ({sel_valid, grant, sel, busy} !== 8'b0_0000_00_0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: valid=%b grant=%b sel=%0d busy=%b, expected all zero",
                         k, sel_valid, grant, sel, busy);
            end
        end
        rst = 1'b0;
        req = 4'b0000;
        tick(1);
        tests_run++;
        if ({sel_valid, grant, busy} !== 6'b0_0000_0) begin
            tests_failed++;
            $display("FAIL idle_no_req: valid=%b grant=%b busy=%b, expected 0/0000/0",
                     sel_valid, grant, busy);
        end
    endtask

    // Single requester: granted one cycle later, re-granted every DWELL cycles.
    task automatic test_single_dwell;
        do_reset(4'b0100);
        out_ready = 1'b1;
        tick(1);
        tests_run++;
        if ({sel_valid, sel, grant, busy} !== 8'b1_10_0100_1) begin
            tests_failed++;
            $display("FAIL single_grant: valid=%b sel=%0d grant=%b busy=%b, expected 1/2/0100/1",
                     sel_valid, sel, grant, busy);
        end
        for (int g = 0; g < 3; g++) begin
            tests_run++;
            if (dut.cnt !== 5'd0) begin
                tests_failed++;
                $display("FAIL regrant_cnt_start[%0d]: cnt=%0d expected 0", g, dut.cnt);
            end
            tick(DWELL - 1);
            tests_run++;
            if (dut.cnt !== 5'(DWELL - 1) || sel !== 2'd2 || sel_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL regrant_cnt_end[%0d]: cnt=%0d sel=%0d valid=%b, expected 15/2/1",
                         g, dut.cnt, sel, sel_valid);
            end
            tick(1);
            tests_run++;
            if (sel_valid !== 1'b1 || sel !== 2'd2 || grant !== 4'b0100) begin
                tests_failed++;
                $display("FAIL regrant_hold[%0d]: valid=%b sel=%0d grant=%b, expected 1/2/0100",
                         g, sel_valid, sel, grant);
            end
        end
        req = 4'b0000;
        tick(1);
        tests_run++;
        if ({sel_valid, grant, busy, sel} !== 8'b0_0000_0_10) begin
            tests_failed++;
            $display("FAIL single_idle: valid=%b grant=%b busy=%b sel=%0d, expected 0/0000/0/2",
                     sel_valid, grant, busy, sel);
        end
    endtask

    // All requesting: 0,1,2,3,0 each for exactly DWELL cycles, no gaps.
    task automatic test_round_robin;
        logic [1:0] seq [5];
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
        do_reset(4'b1111);
        out_ready = 1'b1;
        tick(1);
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < DWELL; k++) begin
                tests_run++;
                if (sel_valid !== 1'b1 || sel !== seq[s] || grant !== (4'b0001 << seq[s])) begin
                    tests_failed++;
                    $display("FAIL rr_slot%0d_cyc%0d: valid=%b sel=%0d grant=%b, expected sel=%0d",
                             s, k, sel_valid, sel, grant, seq[s]);
                end
                tick(1);
            end
        end
        tests_run++;
        if (sel !== 2'd1 || sel_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_wrap_next: sel=%0d valid=%b, expected 1/1", sel, sel_valid);
        end
        req = 4'b0000;
        tick(1);
    endtask

    // Dropped request hands over immediately; dropping all returns to idle.
    task automatic test_drop_release;
        do_reset(4'b0010);
        out_ready = 1'b1;
        tick(1);
        tests_run++;
        if (sel !== 2'd1 || grant !== 4'b0010) begin
            tests_failed++;
            $display("FAIL drop_first_grant: sel=%0d grant=%b, expected 1/0010", sel, grant);
        end
        tick(3);
        req = 4'b1001;
        tick(1);
        tests_run++;
        if ({sel_valid, sel, grant} !== 7'b1_11_1000) begin
            tests_failed++;
            $display("FAIL drop_handover: valid=%b sel=%0d grant=%b, expected 1/3/1000",
                     sel_valid, sel, grant);
        end
        tests_run++;
        if (dut.cnt !== 5'd0) begin
            tests_failed++;
            $display("FAIL drop_cnt_clear: cnt=%0d expected 0", dut.cnt);
        end
        req = 4'b0000;
        tick(1);
        tests_run++;
        if ({sel_valid, grant, busy, sel} !== 8'b0_0000_0_11) begin
            tests_failed++;
            $display("FAIL drop_to_idle: valid=%b grant=%b busy=%b sel=%0d, expected 0/0000/0/3",
                     sel_valid, grant, busy, sel);
        end
    endtask

    // out_ready low freezes the dwell; a dropped request still releases.
    task automatic test_out_ready_freeze;
        do_reset(4'b0011);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tests_run++;
            if (sel !== 2'd0 || sel_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL freeze_hold[%0d]: sel=%0d valid=%b, expected 0/1", k, sel, sel_valid);
            end
            tick(1);
        end
        out_ready = 1'b1;
        tick(DWELL - 1);
        tests_run++;
        if (sel !== 2'd0 || sel_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL freeze_resume_hold: sel=%0d valid=%b, expected 0/1", sel, sel_valid);
        end
        tick(1);
        tests_run++;
        if (sel !== 2'd1 || grant !== 4'b0010 || sel_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL freeze_resume_switch: sel=%0d grant=%b valid=%b, expected 1/0010/1",
                     sel, grant, sel_valid);
        end
        out_ready = 1'b0;
        req       = 4'b0001;
        tick(1);
        tests_run++;
        if (sel !== 2'd0 || grant !== 4'b0001 || sel_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL freeze_drop_release: sel=%0d grant=%b valid=%b, expected 0/0001/1",
                     sel, grant, sel_valid);
        end
        req       = 4'b0000;
        out_ready = 1'b1;
        tick(1);
    endtask

    // Reset in the middle of a grant discards it and restarts the search at 0.
    task automatic test_reset_mid_grant;
        do_reset(4'b1000);
        out_ready = 1'b1;
        tick(5);
        tests_run++;
        if (sel !== 2'd3 || sel_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre: sel=%0d valid=%b, expected 3/1", sel, sel_valid);
        end
        rst = 1'b1;
        req = 4'b1111;
        tick(1);
        tests_run++;
        if ({sel_valid, grant, sel, busy} !== 8'b0_0000_00_0) begin
            tests_failed++;
            $display("FAIL midrst_clear: valid=%b grant=%b sel=%0d busy=%b, expected all zero",
                     sel_valid, grant, sel, busy);
        end
        rst = 1'b0;
        tick(1);
        tests_run++;
        if (sel !== 2'd0 || grant !== 4'b0001 || dut.cnt !== 5'd0) begin
            tests_failed++;
            $display("FAIL midrst_regrant: sel=%0d grant=%b cnt=%0d, expected 0/0001/0",
                     sel, grant, dut.cnt);
        end
        req = 4'b0000;
        tick(1);
    endtask

`ifdef SEL_LOCK_EN
    // Lock holds the grant past any number of dwells; unlocking expires at once.
    task automatic test_lock;
        lock = 1'b1;
        do_reset(4'b0011);
        out_ready = 1'b1;
        tick(1);
        for (int k = 0; k < 120; k++) begin
            tests_run++;
            if (sel !== 2'd0 || sel_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL lock_hold[%0d]: sel=%0d valid=%b, expected 0/1", k, sel, sel_valid);
            end
            tick(1);
        end
        tests_run++;
        if (dut.cnt !== 5'(DWELL - 1)) begin
            tests_failed++;
            $display("FAIL lock_saturate: cnt=%0d expected 15", dut.cnt);
        end
        lock = 1'b0;
        tick(1);
        tests_run++;
        if (sel !== 2'd1 || grant !== 4'b0010) begin
            tests_failed++;
            $display("FAIL lock_release: sel=%0d grant=%b, expected 1/0010", sel, grant);
        end
        req = 4'b0000;
        tick(1);
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        req          = 4'b0000;
        out_ready    = 1'b0;
`ifdef SEL_LOCK_EN
        lock         = 1'b0;
`endif
        test_reset();
        test_single_dwell();
        test_round_robin();
        test_drop_release();
        test_out_ready_freeze();
        test_reset_mid_grant();
`ifdef SEL_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
